pdp8_mem_port_monitor: RTL

Synthesizable, parametrised protocol monitor for the PDP-8 memory request ports: IFU read, EXEC read and EXEC write. It generalises the single IFU address-validity assertion to NUM_PORTS channels. Per port it checks address setup and hold, stall gating, request timeout and address range. It reports registered sticky flags, saturating error counters and a first-error capture. It sits beside the memory arbiter, observes only, and drives nothing back into the datapath.

---
 rtl/pdp8_mem_port_monitor.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/pdp8_mem_port_monitor.sv
`default_nettype none
// ============================================================================
// Module      : pdp8_mem_port_monitor
// Description : Passive protocol monitor for the PDP-8 memory request ports
//               (0 = IFU read, 1 = EXEC read, 2 = EXEC write). Per port it
//               checks address setup before a request rises, address hold
//               while the request is high, requests during a stall, request
//               timeout and address range. Results are reported as a
//               one-cycle error pulse, sticky code bits, saturating error
//               counters and a first-error capture. Observes only.
//
// Ports       : clk, reset        - clock, synchronous active-high reset
//               enable            - 1 = detection active (tracking always runs)
//               clear_err         - clears sticky flags, counters, capture
//               stall             - EXEC stall
//               req / addr        - per-port request and packed address bus
//               base_addr /
//               limit_addr        - inclusive legal address range
//               err_pulse         - per port, error seen in previous cycle
//               err_sticky        - per port 5-bit code, sticky
//                                   [0] SETUP [1] HOLD [2] STALL
//                                   [3] TIMEOUT [4] RANGE
//               err_count         - per port saturating error-cycle count
//               first_err_*       - capture of the first error after clear
//
// Revision    : 1.0 - initial release
// ============================================================================
module pdp8_mem_port_monitor #(
    parameter int                   ADDR_WIDTH     = 12,
    parameter int                   NUM_PORTS      = 3,
    parameter int                   SETUP_CYCLES   = 3,
    parameter int                   MAX_REQ_CYCLES = 8,
    parameter logic [NUM_PORTS-1:0] STALL_MASK     = 3'b001,
    parameter int                   CNT_WIDTH      = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            clear_err,
    input  logic                            stall,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic [ADDR_WIDTH-1:0]           limit_addr,
    output logic [NUM_PORTS-1:0]            err_pulse,
    output logic [NUM_PORTS*5-1:0]          err_sticky,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]  err_count,
    output logic                            first_err_valid,
    output logic [$clog2(NUM_PORTS)-1:0]    first_err_port,
    output logic [4:0]                      first_err_code,
    output logic [ADDR_WIDTH-1:0]           first_err_addr
);

    localparam int c_STABLE_W = $clog2(SETUP_CYCLES + 1);
    localparam int c_REQ_W    = $clog2(MAX_REQ_CYCLES + 1);
    localparam int c_PORT_W   = $clog2(NUM_PORTS);

    localparam logic [c_STABLE_W-1:0] c_SETUP   = c_STABLE_W'(SETUP_CYCLES);
    localparam logic [c_REQ_W-1:0]    c_MAX_REQ = c_REQ_W'(MAX_REQ_CYCLES);

    // Per-port request FSM; the state register doubles as the previous
    // cycle's request (IDLE = req_q 0, ACTIVE = req_q 1).
    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_ACTIVE = 1'b1;

    logic [4:0]           w_err [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_port_err;

    // ------------------------------------------------------------------------
    // Per-port tracking and detection
    // ------------------------------------------------------------------------
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [ADDR_WIDTH-1:0] w_addr;
        logic [ADDR_WIDTH-1:0] r_addr_q;
        logic [0:0]            r_state;
        logic [c_STABLE_W-1:0] r_stable_cnt;
        logic [c_STABLE_W-1:0] w_eff;
        logic [c_REQ_W-1:0]    r_req_cnt;
        logic [c_REQ_W-1:0]    w_req_cnt_inc;
        logic                  r_to_done;
        logic                  w_rise;
        logic                  w_active_hi;
        logic                  w_timeout_hit;

        assign w_addr = addr[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Number of consecutive preceding cycles holding the current address,
        // saturating at SETUP_CYCLES.
        assign w_eff = (w_addr != r_addr_q)     ? '0 :
                       (r_stable_cnt < c_SETUP) ? r_stable_cnt + c_STABLE_W'(1) :
                                                  c_SETUP;

        assign w_rise        = (r_state == c_IDLE) && req[p];
        assign w_active_hi   = (r_state == c_ACTIVE) && req[p];
        assign w_req_cnt_inc = (r_req_cnt == c_MAX_REQ) ? r_req_cnt
                                                        : r_req_cnt + c_REQ_W'(1);
        // Count reaching the limit on this cycle marks the (MAX+1)-th high
        // cycle of the request; to_done keeps it to a single report.
        assign w_timeout_hit = w_active_hi && (w_req_cnt_inc == c_MAX_REQ);

        assign w_err[p] = {5{enable}} & {
            w_rise && ((w_addr < base_addr) || (w_addr > limit_addr)),  // RANGE
            w_timeout_hit && !r_to_done,                                // TIMEOUT
            req[p] && stall && STALL_MASK[p],                           // STALL
            w_active_hi && (w_addr != r_addr_q),                        // HOLD
            w_rise && (w_eff < c_SETUP)                                 // SETUP
        };

        assign w_port_err[p] = |w_err[p];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_addr_q     <= '0;
                r_state      <= c_IDLE;
                r_stable_cnt <= '0;
                r_req_cnt    <= '0;
                r_to_done    <= 1'b0;
            end else begin
                r_addr_q     <= w_addr;
                r_stable_cnt <= w_eff;
                case (r_state)
                    c_IDLE: begin
                        if (req[p]) begin
                            r_state <= c_ACTIVE;
                        end
                    end
                    c_ACTIVE: begin
                        if (!req[p]) begin
                            r_state   <= c_IDLE;
                            r_req_cnt <= '0;
                            r_to_done <= 1'b0;
                        end else begin
                            r_req_cnt <= w_req_cnt_inc;
                            if (w_timeout_hit) begin
                                r_to_done <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // First-error selection: the lowest-indexed erring port wins, so scan
    // downwards and let the last hit stand.
    // ------------------------------------------------------------------------
    logic                  w_any_err;
    logic [c_PORT_W-1:0]   w_sel_port;
    logic [4:0]            w_sel_code;
    logic [ADDR_WIDTH-1:0] w_sel_addr;

    always_comb begin
        w_any_err  = 1'b0;
        w_sel_port = '0;
        w_sel_code = '0;
        w_sel_addr = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (w_port_err[p]) begin
                w_any_err  = 1'b1;
                w_sel_port = c_PORT_W'(p);
                w_sel_code = w_err[p];
                w_sel_addr = addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Recording. A clear coinciding with a new error restarts the records
    // from that error rather than discarding it.
    // ------------------------------------------------------------------------
    logic [NUM_PORTS-1:0]           r_err_pulse;
    logic [NUM_PORTS*5-1:0]         r_err_sticky;
    logic [NUM_PORTS*CNT_WIDTH-1:0] r_err_count;
    logic                           r_first_valid;
    logic [c_PORT_W-1:0]            r_first_port;
    logic [4:0]                     r_first_code;
    logic [ADDR_WIDTH-1:0]          r_first_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_pulse   <= '0;
            r_err_sticky  <= '0;
            r_err_count   <= '0;
            r_first_valid <= 1'b0;
            r_first_port  <= '0;
            r_first_code  <= '0;
            r_first_addr  <= '0;
        end else begin
            r_err_pulse <= w_port_err;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (clear_err) begin
                    r_err_sticky[p*5 +: 5]               <= w_err[p];
                    r_err_count[p*CNT_WIDTH +: CNT_WIDTH] <= CNT_WIDTH'(w_port_err[p]);
                end else begin
                    r_err_sticky[p*5 +: 5] <= r_err_sticky[p*5 +: 5] | w_err[p];
                    if (w_port_err[p] && !(&r_err_count[p*CNT_WIDTH +: CNT_WIDTH])) begin
                        r_err_count[p*CNT_WIDTH +: CNT_WIDTH] <=
                            r_err_count[p*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
                    end
                end
            end
            if (w_any_err && (clear_err || !r_first_valid)) begin
                r_first_valid <= 1'b1;
                r_first_port  <= w_sel_port;
                r_first_code  <= w_sel_code;
                r_first_addr  <= w_sel_addr;
            end else if (clear_err) begin
                r_first_valid <= 1'b0;
                r_first_port  <= '0;
                r_first_code  <= '0;
                r_first_addr  <= '0;
            end
        end
    end

    assign err_pulse       = r_err_pulse;
    assign err_sticky      = r_err_sticky;
    assign err_count       = r_err_count;
    assign first_err_valid = r_first_valid;
    assign first_err_port  = r_first_port;
    assign first_err_code  = r_first_code;
    assign first_err_addr  = r_first_addr;

endmodule
`default_nettype wire
